// File: rtl/jellyvl_etherneco_packet_rx.sv
// Receive-side parser for the etherneco ring packet format: strips preamble, header and FCS,
// forwards payload bytes downstream and reports the header fields and CRC status per packet.
module jellyvl_etherneco_packet_rx #(
    parameter logic [15:0] PAYLOAD_MAX = 16'hffff
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        s_first,
    input  logic        s_last,
    input  logic [7:0]  s_data,
    input  logic        s_valid,

    output logic        rx_start,
    output logic        rx_end,
    output logic        rx_error,
    output logic [15:0] rx_length,
    output logic [7:0]  rx_type,
    output logic [7:0]  rx_node,

    output logic        m_first,
    output logic        m_last,
    output logic [7:0]  m_data,
    output logic        m_valid
);

    localparam logic [31:0] CRC_POLY  = 32'h04c11db7;
    localparam logic [31:0] CRC_INIT  = 32'hffffffff;
    localparam logic [16:0] LEN_LIMIT = {1'b0, PAYLOAD_MAX};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LENGTH,
        ST_TYPE,
        ST_NODE,
        ST_PAYLOAD,
        ST_FCS,
        ST_ERROR
    } state_t;

    // CRC-32, non-reflected, MSB of each byte first, no final XOR.
    function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t      r_state,     w_state;
    logic [1:0]  r_idx,       w_idx;
    logic [15:0] r_len,       w_len;
    logic [7:0]  r_type_tmp,  w_type_tmp;
    logic [31:0] r_crc,       w_crc;
    logic [23:0] r_fcs,       w_fcs;
    logic [15:0] r_cnt,       w_cnt;
    logic        r_first,     w_first;
    logic        r_started,   w_started;

    logic        r_rx_start,  w_rx_start;
    logic        r_rx_end,    w_rx_end;
    logic        r_rx_error,  w_rx_error;
    logic [15:0] r_rx_length, w_rx_length;
    logic [7:0]  r_rx_type,   w_rx_type;
    logic [7:0]  r_rx_node,   w_rx_node;
    logic        r_m_first,   w_m_first;
    logic        r_m_last,    w_m_last;
    logic [7:0]  r_m_data,    w_m_data;
    logic        r_m_valid,   w_m_valid;

    always_comb begin
        // NOTE: every w_ signal gets a default first, so no path through the case infers a latch.
        w_state     = r_state;
        w_idx       = r_idx;
        w_len       = r_len;
        w_type_tmp  = r_type_tmp;
        w_crc       = r_crc;
        w_fcs       = r_fcs;
        w_cnt       = r_cnt;
        w_first     = r_first;
        w_started   = r_started;
        w_rx_start  = 1'b0;
        w_rx_end    = 1'b0;
        w_rx_error  = 1'b0;
        w_rx_length = r_rx_length;
        w_rx_type   = r_rx_type;
        w_rx_node   = r_rx_node;
        w_m_first   = 1'b0;
        w_m_last    = 1'b0;
        w_m_data    = r_m_data;
        w_m_valid   = 1'b0;

        if (s_valid) begin
            if (s_first && r_state != ST_IDLE && r_state != ST_PREAMBLE) begin
                // A new frame overtakes the current one; report the loss only if it was announced.
                w_rx_end   = r_started;
                w_rx_error = r_started;
                w_started  = 1'b0;
                w_crc      = CRC_INIT;
                w_state    = (s_data == 8'h55) ? ST_PREAMBLE : ST_ERROR;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (s_first && s_data == 8'h55) begin
                            w_state = ST_PREAMBLE;
                            w_crc   = CRC_INIT;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (s_data == 8'hd5) begin
                            w_state = ST_LENGTH;
                            w_idx   = 2'd0;
                        end else if (s_data != 8'h55) begin
                            w_state = ST_ERROR;
                        end
                    end
                    ST_LENGTH: begin
                        w_crc = crc_update(r_crc, s_data);
                        if (r_idx == 2'd0) begin
                            w_len[7:0] = s_data;
                            w_idx      = 2'd1;
                        end else begin
                            w_len[15:8] = s_data;
                            w_state     = ST_TYPE;
                        end
                    end
                    ST_TYPE: begin
                        w_crc      = crc_update(r_crc, s_data);
                        w_type_tmp = s_data;
                        w_state    = ST_NODE;
                    end
                    ST_NODE: begin
                        w_crc = crc_update(r_crc, s_data);
                        if ({1'b0, r_len} > LEN_LIMIT) begin
                            w_state = ST_ERROR;
                        end else if (!s_last) begin
                            w_rx_start  = 1'b1;
                            w_rx_length = r_len;
                            w_rx_type   = r_type_tmp;
                            w_rx_node   = s_data;
                            w_cnt       = r_len;
                            w_first     = 1'b1;
                            w_started   = 1'b1;
                            w_state     = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        // A byte carrying s_last here is an abort marker, never payload.
                        if (!s_last) begin
                            w_m_valid = 1'b1;
                            w_m_data  = s_data;
                            w_m_first = r_first;
                            w_m_last  = (r_cnt == 16'd0);
                            w_first   = 1'b0;
                            w_crc     = crc_update(r_crc, s_data);
                            w_cnt     = r_cnt - 16'd1;
                            if (r_cnt == 16'd0) begin
                                w_state = ST_FCS;
                                w_idx   = 2'd0;
                            end
                        end
                    end
                    ST_FCS: begin
                        w_fcs = {s_data, r_fcs[23:8]};
                        w_idx = r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            w_rx_end   = 1'b1;
                            w_rx_error = ({s_data, r_fcs} != r_crc);
                            w_state    = ST_IDLE;
                        end
                    end
                    ST_ERROR: begin
                    end
                    default: begin
                        w_state = ST_IDLE;
                    end
                endcase
            end

            if (s_last && w_state != ST_IDLE) begin
                w_rx_end   = 1'b1;
                w_rx_error = 1'b1;
                w_state    = ST_IDLE;
            end
        end

        if (w_state == ST_IDLE) begin
            w_started = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_len       <= 16'd0;
            r_type_tmp  <= 8'd0;
            r_crc       <= CRC_INIT;
            r_fcs       <= 24'd0;
            r_cnt       <= 16'd0;
            r_first     <= 1'b0;
            r_started   <= 1'b0;
            r_rx_start  <= 1'b0;
            r_rx_end    <= 1'b0;
            r_rx_error  <= 1'b0;
            r_rx_length <= 16'd0;
            r_rx_type   <= 8'd0;
            r_rx_node   <= 8'd0;
            r_m_first   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_data    <= 8'd0;
            r_m_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_len       <= w_len;
            r_type_tmp  <= w_type_tmp;
            r_crc       <= w_crc;
            r_fcs       <= w_fcs;
            r_cnt       <= w_cnt;
            r_first     <= w_first;
            r_started   <= w_started;
            r_rx_start  <= w_rx_start;
            r_rx_end    <= w_rx_end;
            r_rx_error  <= w_rx_error;
            r_rx_length <= w_rx_length;
            r_rx_type   <= w_rx_type;
            r_rx_node   <= w_rx_node;
            r_m_first   <= w_m_first;
            r_m_last    <= w_m_last;
            r_m_data    <= w_m_data;
            r_m_valid   <= w_m_valid;
        end
    end

    assign rx_start  = r_rx_start;
    assign rx_end    = r_rx_end;
    assign rx_error  = r_rx_error;
    assign rx_length = r_rx_length;
    assign rx_type   = r_rx_type;
    assign rx_node   = r_rx_node;
    assign m_first   = r_m_first;
    assign m_last    = r_m_last;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;

endmodule

// File: tb/tb_jellyvl_etherneco_packet_rx.sv
// Self-checking bench for jellyvl_etherneco_packet_rx: frame-level model of expected events
// (header, payload beats, end status with cycle) compared against the observed output events.
module tb_jellyvl_etherneco_packet_rx;

    localparam logic [31:0] POLY = 32'h04c11db7;
    localparam int EV_START = 1;
    localparam int EV_BEAT  = 2;
    localparam int EV_END   = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  typ;
        logic [7:0]  node;
        logic [7:0]  base;
        logic [7:0]  step;
        int          npre;
        bit          corrupt;
        int          cancel;
        bit          abort_prev;
    } frame_t;

    typedef struct {
        frame_t f;
        int     n_beats;
        bit     has_last;
        bit     err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_first = 1'b0, s_last = 1'b0, s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;

    logic        rx_start, rx_end, rx_error, m_first, m_last, m_valid;
    logic [15:0] rx_length;
    logic [7:0]  rx_type, rx_node, m_data;
    logic        b_rx_start, b_rx_end, b_rx_error, b_m_first, b_m_last, b_m_valid;
    logic [15:0] b_rx_length;
    logic [7:0]  b_rx_type, b_rx_node, b_m_data;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    ev_t act_q[$];
    ev_t act_b_q[$];

    jellyvl_etherneco_packet_rx dut (
        .clk(clk), .reset_n(reset_n),
        .s_first(s_first), .s_last(s_last), .s_data(s_data), .s_valid(s_valid),
        .rx_start(rx_start), .rx_end(rx_end), .rx_error(rx_error),
        .rx_length(rx_length), .rx_type(rx_type), .rx_node(rx_node),
        .m_first(m_first), .m_last(m_last), .m_data(m_data), .m_valid(m_valid)
    );

    jellyvl_etherneco_packet_rx #(.PAYLOAD_MAX(16'h00ff)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .s_first(s_first), .s_last(s_last), .s_data(s_data), .s_valid(s_valid),
        .rx_start(b_rx_start), .rx_end(b_rx_end), .rx_error(b_rx_error),
        .rx_length(b_rx_length), .rx_type(b_rx_type), .rx_node(b_rx_node),
        .m_first(b_m_first), .m_last(b_m_last), .m_data(b_m_data), .m_valid(b_m_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int kind, input logic [31:0] val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        return e;
    endfunction

    function automatic logic [63:0] key(input ev_t e);
        return {8'(e.kind), 24'(e.cyc), e.val};
    endfunction

    // Output events become visible at the falling edge after the registering edge.
    always @(negedge clk) begin
        if (rx_start) act_q.push_back(mk_ev(EV_START, {rx_length, rx_type, rx_node}, cyc));
        if (m_valid)  act_q.push_back(mk_ev(EV_BEAT, {22'd0, m_first, m_last, m_data}, cyc));
        if (rx_end)   act_q.push_back(mk_ev(EV_END, {31'd0, rx_error}, cyc));
        if (b_rx_start) act_b_q.push_back(mk_ev(EV_START, {b_rx_length, b_rx_type, b_rx_node}, cyc));
        if (b_m_valid)  act_b_q.push_back(mk_ev(EV_BEAT, {22'd0, b_m_first, b_m_last, b_m_data}, cyc));
        if (b_rx_end)   act_b_q.push_back(mk_ev(EV_END, {31'd0, b_rx_error}, cyc));
    end

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {d, 24'h0};
        repeat (8) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    function automatic frame_t mk_frame(input logic [15:0] len, input logic [7:0] typ,
                                        input logic [7:0] node, input logic [7:0] base,
                                        input logic [7:0] step, input int npre,
                                        input bit corrupt, input int cancel, input bit abort_prev);
        frame_t f;
        f.len = len; f.typ = typ; f.node = node; f.base = base; f.step = step;
        f.npre = npre; f.corrupt = corrupt; f.cancel = cancel; f.abort_prev = abort_prev;
        return f;
    endfunction

    function automatic vec_t mk_vec(input frame_t f, input int n_beats, input bit has_last, input bit err);
        vec_t v;
        v.f = f; v.n_beats = n_beats; v.has_last = has_last; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; c returns the cycle number of the edge that samples the byte.
    task automatic send_byte(input logic [7:0] d, input logic f, input logic l,
                             input int gap_pct, output int c);
        for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
            s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1; s_first = f; s_last = l; s_data = d;
        c = cyc + 1;
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int gap_pct);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  p;
        int          c;
        crc = 32'hffffffff;
        for (int i = 0; i < f.npre; i++) begin
            send_byte(8'h55, i == 0, 1'b0, gap_pct, c);
            if (i == 0 && f.abort_prev) exp_q.push_back(mk_ev(EV_END, 32'd1, c));
        end
        send_byte(8'hd5, 1'b0, 1'b0, gap_pct, c);
        crc = crc8(crc, f.len[7:0]);  send_byte(f.len[7:0], 1'b0, 1'b0, gap_pct, c);
        crc = crc8(crc, f.len[15:8]); send_byte(f.len[15:8], 1'b0, 1'b0, gap_pct, c);
        crc = crc8(crc, f.typ);       send_byte(f.typ, 1'b0, 1'b0, gap_pct, c);
        crc = crc8(crc, f.node);      send_byte(f.node, 1'b0, 1'b0, gap_pct, c);
        exp_q.push_back(mk_ev(EV_START, {f.len, f.typ, f.node}, c));
        for (int j = 0; j <= int'(f.len); j++) begin
            if (j == f.cancel) begin
                send_byte(8'h00, 1'b0, 1'b1, gap_pct, c);
                exp_q.push_back(mk_ev(EV_END, 32'd1, c));
                return;
            end
            p = f.base + f.step * 8'(j);
            crc = crc8(crc, p);
            send_byte(p, 1'b0, 1'b0, gap_pct, c);
            exp_q.push_back(mk_ev(EV_BEAT, {22'd0, j == 0, j == int'(f.len), p}, c));
        end
        fcs = crc ^ {31'd0, f.corrupt};
        for (int k = 0; k < 4; k++) begin
            send_byte(fcs[8*k +: 8], 1'b0, k == 3, gap_pct, c);
        end
        exp_q.push_back(mk_ev(EV_END, {31'd0, f.corrupt}, c));
    endtask

    task automatic compare_events(input string tag, input bit use_b);
        int  na;
        ev_t a;
        na = use_b ? act_b_q.size() : act_q.size();
        check({tag, " event count"}, 64'(na), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < na; i++) begin
            if (use_b) a = act_b_q[i];
            else       a = act_q[i];
            check($sformatf("%s event %0d", tag, i), key(a), key(exp_q[i]));
        end
        exp_q.delete(); act_q.delete(); act_b_q.delete();
    endtask

    initial begin
        vec_t   tbl [6];
        frame_t f;
        int     c;
        int     ns, nb, nl, ne;
        logic   err;

        tbl[0] = mk_vec(mk_frame(16'h0003, 8'h10, 8'h02, 8'ha1, 8'h01, 6, 1'b0, -1, 1'b0), 4, 1'b1, 1'b0);
        tbl[1] = mk_vec(mk_frame(16'h0003, 8'h10, 8'h02, 8'ha1, 8'h01, 6, 1'b1, -1, 1'b0), 4, 1'b1, 1'b1);
        tbl[2] = mk_vec(mk_frame(16'h0003, 8'h10, 8'h02, 8'ha1, 8'h01, 6, 1'b0,  2, 1'b0), 2, 1'b0, 1'b1);
        tbl[3] = mk_vec(mk_frame(16'h0000, 8'h33, 8'h44, 8'h5a, 8'h01, 1, 1'b0, -1, 1'b0), 1, 1'b1, 1'b0);
        tbl[4] = mk_vec(mk_frame(16'h0007, 8'h80, 8'hff, 8'h00, 8'h03, 3, 1'b0, -1, 1'b0), 8, 1'b1, 1'b0);
        tbl[5] = mk_vec(mk_frame(16'h0005, 8'h01, 8'h02, 8'h10, 8'h01, 2, 1'b1,  0, 1'b0), 0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("reset outputs", 64'({rx_start, rx_end, rx_error, rx_length, rx_type, rx_node,
                                     m_first, m_last, m_data, m_valid}), 64'd0);
        check("reset outputs small", 64'({b_rx_start, b_rx_end, b_rx_error, b_rx_length, b_rx_type,
                                           b_rx_node, b_m_first, b_m_last, b_m_data, b_m_valid}), 64'd0);
        reset_n = 1'b1;
        idle(2);
        exp_q.delete(); act_q.delete(); act_b_q.delete();

        for (int t = 0; t < 6; t++) begin
            send_frame(tbl[t].f, 0);
            idle(3);
            ns = 0; nb = 0; nl = 0; ne = 0; err = 1'b0;
            for (int i = 0; i < act_q.size(); i++) begin
                if (act_q[i].kind == EV_START) ns++;
                if (act_q[i].kind == EV_BEAT) begin
                    nb++;
                    if (act_q[i].val[8]) nl++;
                end
                if (act_q[i].kind == EV_END) begin
                    ne++;
                    err = act_q[i].val[0];
                end
            end
            check($sformatf("vec%0d rx_start count", t), 64'(ns), 64'd1);
            check($sformatf("vec%0d beat count", t), 64'(nb), 64'(tbl[t].n_beats));
            check($sformatf("vec%0d m_last count", t), 64'(nl), 64'(tbl[t].has_last));
            check($sformatf("vec%0d rx_end count", t), 64'(ne), 64'd1);
            check($sformatf("vec%0d rx_error", t), 64'(err), 64'(tbl[t].err));
            check($sformatf("vec%0d held fields", t), 64'({rx_length, rx_type, rx_node}),
                  64'({tbl[t].f.len, tbl[t].f.typ, tbl[t].f.node}));
            compare_events($sformatf("vec%0d", t), 1'b0);
        end

        // Bad preamble: error only once s_last arrives.
        send_byte(8'h55, 1'b1, 1'b0, 0, c);
        send_byte(8'h54, 1'b0, 1'b0, 0, c);
        send_byte(8'hd5, 1'b0, 1'b0, 0, c);
        send_byte(8'h03, 1'b0, 1'b0, 0, c);
        send_byte(8'h77, 1'b0, 1'b1, 0, c);
        exp_q.push_back(mk_ev(EV_END, 32'd1, c));
        idle(3);
        compare_events("bad preamble", 1'b0);

        // Error-causing byte that is also the last byte ends in the same cycle.
        send_byte(8'h55, 1'b1, 1'b0, 0, c);
        send_byte(8'h54, 1'b0, 1'b1, 0, c);
        exp_q.push_back(mk_ev(EV_END, 32'd1, c));
        idle(3);
        compare_events("bad preamble last", 1'b0);

        // Oversize length on the instance limited to 255-byte fields.
        send_byte(8'h55, 1'b1, 1'b0, 0, c);
        send_byte(8'hd5, 1'b0, 1'b0, 0, c);
        send_byte(8'h00, 1'b0, 1'b0, 0, c);
        send_byte(8'h01, 1'b0, 1'b0, 0, c);
        send_byte(8'h10, 1'b0, 1'b0, 0, c);
        send_byte(8'h02, 1'b0, 1'b0, 0, c);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hc0 + i), 1'b0, i == 4, 0, c);
        exp_q.push_back(mk_ev(EV_END, 32'd1, c));
        idle(3);
        compare_events("oversize", 1'b1);

        // Two back-to-back single-byte frames with random gaps.
        send_frame(mk_frame(16'h0000, 8'h21, 8'h31, 8'h9c, 8'h00, 2, 1'b0, -1, 1'b0), 40);
        send_frame(mk_frame(16'h0000, 8'h22, 8'h32, 8'h3e, 8'h00, 1, 1'b0, -1, 1'b0), 40);
        idle(3);
        compare_events("back to back len0", 1'b0);

        // New frame start overtaking an announced packet.
        send_byte(8'h55, 1'b1, 1'b0, 0, c);
        send_byte(8'hd5, 1'b0, 1'b0, 0, c);
        send_byte(8'h02, 1'b0, 1'b0, 0, c);
        send_byte(8'h00, 1'b0, 1'b0, 0, c);
        send_byte(8'h41, 1'b0, 1'b0, 0, c);
        send_byte(8'h42, 1'b0, 1'b0, 0, c);
        exp_q.push_back(mk_ev(EV_START, {16'h0002, 8'h41, 8'h42}, c));
        send_byte(8'he7, 1'b0, 1'b0, 0, c);
        exp_q.push_back(mk_ev(EV_BEAT, {22'd0, 1'b1, 1'b0, 8'he7}, c));
        send_frame(mk_frame(16'h0002, 8'h51, 8'h52, 8'h70, 8'h11, 2, 1'b0, -1, 1'b1), 0);
        idle(3);
        compare_events("abort after start", 1'b0);

        // New frame start inside the header: no rx_end for the unannounced packet.
        send_byte(8'h55, 1'b1, 1'b0, 0, c);
        send_byte(8'hd5, 1'b0, 1'b0, 0, c);
        send_byte(8'h01, 1'b0, 1'b0, 0, c);
        send_frame(mk_frame(16'h0001, 8'h61, 8'h62, 8'h80, 8'h05, 1, 1'b0, -1, 1'b0), 0);
        idle(3);
        compare_events("abort in header", 1'b0);

        // Reset in the middle of the payload.
        send_byte(8'h55, 1'b1, 1'b0, 0, c);
        send_byte(8'hd5, 1'b0, 1'b0, 0, c);
        send_byte(8'h05, 1'b0, 1'b0, 0, c);
        send_byte(8'h00, 1'b0, 1'b0, 0, c);
        send_byte(8'h21, 1'b0, 1'b0, 0, c);
        send_byte(8'h22, 1'b0, 1'b0, 0, c);
        exp_q.push_back(mk_ev(EV_START, {16'h0005, 8'h21, 8'h22}, c));
        send_byte(8'hb0, 1'b0, 1'b0, 0, c);
        exp_q.push_back(mk_ev(EV_BEAT, {22'd0, 1'b1, 1'b0, 8'hb0}, c));
        send_byte(8'hb1, 1'b0, 1'b0, 0, c);
        exp_q.push_back(mk_ev(EV_BEAT, {22'd0, 1'b0, 1'b0, 8'hb1}, c));
        reset_n = 1'b0;
        @(negedge clk);
        check("mid-frame reset outputs", 64'({rx_start, rx_end, rx_error, rx_length, rx_type, rx_node,
                                               m_first, m_last, m_data, m_valid}), 64'd0);
        reset_n = 1'b1;
        send_frame(mk_frame(16'h0004, 8'h10, 8'h02, 8'hd0, 8'h01, 4, 1'b0, -1, 1'b0), 0);
        idle(3);
        compare_events("reset mid payload", 1'b0);

        // Randomized frames, gaps and back-to-back starts against the frame-level model.
        for (int r = 0; r < 40; r++) begin
            f.len        = 16'($urandom_range(20));
            f.typ        = 8'($urandom);
            f.node       = 8'($urandom);
            f.base       = 8'($urandom);
            f.step       = 8'($urandom);
            f.npre       = int'($urandom_range(1, 7));
            f.corrupt    = ($urandom_range(3) == 0);
            f.cancel     = ($urandom_range(4) == 0) ? int'($urandom_range(int'(f.len))) : -1;
            f.abort_prev = 1'b0;
            send_frame(f, 25);
            if ($urandom_range(1) == 1) idle(int'($urandom_range(3)));
            if (r % 5 == 4) begin
                idle(3);
                compare_events($sformatf("random group %0d", r / 5), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
